// File: rtl/regfile_write_scheduler_pkg.sv
// Shared register-file bus types and sizing helpers for the write-port scheduler.
package regfile_write_scheduler_pkg;

  localparam int unsigned REG_ADDR_BUS_W = 5;
  localparam int unsigned WORD_BUS_W     = 32;
  localparam int unsigned REG_NUM_CORE   = 32;

  typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;
  typedef logic [WORD_BUS_W-1:0]     word_bus_t;

  localparam reg_addr_bus_t REG_ZERO = '0;

  // Counter must be able to hold the value `limit` itself.
  function automatic int unsigned starve_cnt_w(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_hold_buffer.sv
// One-entry valid/ready holding register for a pending MDU writeback.
module wb_hold_buffer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  input  logic              drain_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              capture;

  assign in_ready_o = ~valid_q;
  assign capture    = in_valid_i && !valid_q;

  always_comb begin
    valid_d = valid_q;
    if (drain_i) valid_d = 1'b0;
    if (capture) valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q <= in_addr_i;
      data_q <= in_data_i;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single RF write port between pipeline writeback and a buffered MDU result,
// and keeps a busy scoreboard of outstanding MDU destinations to stall ID.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int unsigned REG_NUM      = REG_NUM_CORE,
  parameter int unsigned ADDR_W       = REG_ADDR_BUS_W,
  parameter int unsigned DATA_W       = WORD_BUS_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              mdu_issue,
  input  logic [ADDR_W-1:0] mdu_issue_addr,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  input  logic [ADDR_W-1:0] id_addr_left,
  input  logic [ADDR_W-1:0] id_addr_right,
  input  logic [ADDR_W-1:0] id_dest,
  output logic              stall_id,
  output logic              wb_bubble_req
);

  localparam int unsigned       CntW = starve_cnt_w(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] Zero = ADDR_W'(REG_ZERO);
  localparam logic [CntW-1:0]   CntMax = CntW'(STARVE_LIMIT);

  logic              hold_valid, hold_ready;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              pipe_real, grant_hold;
  logic              hit_left, hit_right, hit_dest;
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  assign pipe_real  = pipe_we && (pipe_addr != Zero);
  assign grant_hold = hold_valid && !pipe_real && !rst;
  assign mdu_ready  = hold_ready && !rst;

  wb_hold_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_valid_i(mdu_valid),
    .in_addr_i (mdu_addr),
    .in_data_i (mdu_data),
    .in_ready_o(hold_ready),
    .drain_i   (grant_hold),
    .valid_o   (hold_valid),
    .addr_o    (hold_addr),
    .data_o    (hold_data)
  );

  // A hold entry for r0 still drains, it just never asserts the write enable.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    if (!rst) begin
      if (pipe_real) begin
        rf_we   = 1'b1;
        rf_addr = pipe_addr;
        rf_data = pipe_data;
      end else if (hold_valid) begin
        rf_we   = (hold_addr != Zero);
        rf_addr = hold_addr;
        rf_data = hold_data;
      end
    end
  end

  // Clear before set so a re-issue to the draining register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (grant_hold) busy_d[hold_addr] = 1'b0;
    if (mdu_issue && (mdu_issue_addr != Zero)) busy_d[mdu_issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (grant_hold) begin
      cnt_d = '0;
    end else if (hold_valid && pipe_real && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hit_left  = (id_addr_left  != Zero) && busy_q[id_addr_left];
  assign hit_right = (id_addr_right != Zero) && busy_q[id_addr_right];
  assign hit_dest  = (id_dest       != Zero) && busy_q[id_dest];

  assign stall_id      = !rst && (hit_left || hit_right || hit_dest);
  assign wb_bubble_req = !rst && hold_valid && (cnt_q == CntMax);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed, table-driven bench for regfile_write_scheduler.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_addr;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  id_addr_left;
  logic [4:0]  id_addr_right;
  logic [4:0]  id_dest;
  logic        stall_id;
  logic        wb_bubble_req;

  always #5 clk = ~clk;

  regfile_write_scheduler #(
    .REG_NUM     (32),
    .ADDR_W      (5),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_we       (pipe_we),
    .pipe_addr     (pipe_addr),
    .pipe_data     (pipe_data),
    .mdu_issue     (mdu_issue),
    .mdu_issue_addr(mdu_issue_addr),
    .mdu_valid     (mdu_valid),
    .mdu_addr      (mdu_addr),
    .mdu_data      (mdu_data),
    .mdu_ready     (mdu_ready),
    .rf_we         (rf_we),
    .rf_addr       (rf_addr),
    .rf_data       (rf_data),
    .id_addr_left  (id_addr_left),
    .id_addr_right (id_addr_right),
    .id_dest       (id_dest),
    .stall_id      (stall_id),
    .wb_bubble_req (wb_bubble_req)
  );

  // One row = inputs held for one cycle plus the combinational outputs expected in it.
  typedef struct {
    int unsigned rst, pwe, paddr;
    logic [31:0] pdata;
    int unsigned iss, iaddr, mv, maddr;
    logic [31:0] mdata;
    int unsigned idl, idr, idd;
    int unsigned ewe, eaddr;
    logic [31:0] edata;
    int unsigned erdy, estall, ebub;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];
  vec_t v;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input int idx);
    @(negedge clk);
    rst            = t.rst[0];
    pipe_we        = t.pwe[0];
    pipe_addr      = 5'(t.paddr);
    pipe_data      = t.pdata;
    mdu_issue      = t.iss[0];
    mdu_issue_addr = 5'(t.iaddr);
    mdu_valid      = t.mv[0];
    mdu_addr       = 5'(t.maddr);
    mdu_data       = t.mdata;
    id_addr_left   = 5'(t.idl);
    id_addr_right  = 5'(t.idr);
    id_dest        = 5'(t.idd);
    #1;
    chk("rf_we", idx, {31'b0, rf_we}, t.ewe);
    if (t.ewe != 0) begin
      chk("rf_addr", idx, {27'b0, rf_addr}, t.eaddr);
      chk("rf_data", idx, rf_data, t.edata);
    end
    chk("mdu_ready", idx, {31'b0, mdu_ready}, t.erdy);
    chk("stall_id", idx, {31'b0, stall_id}, t.estall);
    chk("wb_bubble_req", idx, {31'b0, wb_bubble_req}, t.ebub);
  endtask

  initial begin
    rst = 1'b1; pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
    mdu_issue = 1'b0; mdu_issue_addr = '0; mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
    id_addr_left = '0; id_addr_right = '0; id_dest = '0;

    //          rst pwe pa pdata         iss ia mv ma mdata          idl idr idd  we ea edata        rdy st bub
    // Reset and idle
    vecs[0]  = '{1, 1, 3, 32'h33,        1, 4, 1, 6, 32'h66,         4, 6, 0,  0, 0, 0,           0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0,             0, 0, 0, 0, 0,              0, 0, 0,  0, 0, 0,           0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0,             0, 0, 0, 0, 0,              4, 6, 0,  0, 0, 0,           1, 0, 0};
    // Basic MDU round trip to r5
    vecs[3]  = '{0, 0, 0, 0,             1, 5, 0, 0, 0,              5, 0, 0,  0, 0, 0,           1, 0, 0};
    vecs[4]  = '{0, 0, 0, 0,             0, 0, 1, 5, 32'h12345678,   5, 0, 0,  0, 0, 0,           1, 1, 0};
    vecs[5]  = '{0, 0, 0, 0,             0, 0, 0, 0, 0,              5, 0, 0,  1, 5, 32'h12345678, 0, 1, 0};
    vecs[6]  = '{0, 0, 0, 0,             0, 0, 0, 0, 0,              5, 0, 0,  0, 0, 0,           1, 0, 0};
    // Starvation: hold r7 while the pipeline writes r1..r4
    vecs[7]  = '{0, 0, 0, 0,             1, 7, 1, 7, 32'hCAFE0007,   0, 0, 0,  0, 0, 0,           1, 0, 0};
    vecs[8]  = '{0, 1, 1, 32'h11,        0, 0, 0, 0, 0,              0, 0, 7,  1, 1, 32'h11,      0, 1, 0};
    vecs[9]  = '{0, 1, 2, 32'h22,        0, 0, 0, 0, 0,              0, 0, 7,  1, 2, 32'h22,      0, 1, 0};
    vecs[10] = '{0, 1, 3, 32'h33,        0, 0, 0, 0, 0,              0, 0, 7,  1, 3, 32'h33,      0, 1, 0};
    vecs[11] = '{0, 1, 4, 32'h44,        0, 0, 0, 0, 0,              0, 0, 7,  1, 4, 32'h44,      0, 1, 0};
    vecs[12] = '{0, 0, 0, 0,             0, 0, 0, 0, 0,              0, 0, 7,  1, 7, 32'hCAFE0007, 0, 1, 1};
    vecs[13] = '{0, 0, 0, 0,             0, 0, 0, 0, 0,              0, 0, 7,  0, 0, 0,           1, 0, 0};
    // Pipeline write to r0 does not block the hold
    vecs[14] = '{0, 0, 0, 0,             1, 10, 1, 10, 32'hA,        0, 0, 0,  0, 0, 0,           1, 0, 0};
    vecs[15] = '{0, 1, 0, 32'hDEAD,      0, 0, 0, 0, 0,              10, 0, 0, 1, 10, 32'hA,      0, 1, 0};
    vecs[16] = '{0, 0, 0, 0,             0, 0, 0, 0, 0,              10, 0, 0, 0, 0, 0,           1, 0, 0};
    // MDU result to r0: drained silently, never busy
    vecs[17] = '{0, 0, 0, 0,             1, 0, 1, 0, 32'h55,         0, 0, 0,  0, 0, 0,           1, 0, 0};
    vecs[18] = '{0, 0, 0, 0,             0, 0, 0, 0, 0,              0, 0, 0,  0, 0, 0,           0, 0, 0};
    vecs[19] = '{0, 0, 0, 0,             0, 0, 0, 0, 0,              0, 0, 0,  0, 0, 0,           1, 0, 0};
    // Counter restarts from 0 after a drain and saturates at the limit
    vecs[20] = '{0, 0, 0, 0,             0, 0, 1, 11, 32'hB,         0, 0, 0,  0, 0, 0,           1, 0, 0};
    vecs[21] = '{0, 1, 1, 32'h1,         0, 0, 0, 0, 0,              0, 0, 0,  1, 1, 32'h1,       0, 0, 0};
    vecs[22] = '{0, 1, 2, 32'h2,         0, 0, 0, 0, 0,              0, 0, 0,  1, 2, 32'h2,       0, 0, 0};
    vecs[23] = '{0, 1, 3, 32'h3,         0, 0, 0, 0, 0,              0, 0, 0,  1, 3, 32'h3,       0, 0, 0};
    vecs[24] = '{0, 1, 4, 32'h4,         0, 0, 0, 0, 0,              0, 0, 0,  1, 4, 32'h4,       0, 0, 0};
    vecs[25] = '{0, 1, 5, 32'h55,        0, 0, 0, 0, 0,              0, 0, 0,  1, 5, 32'h55,      0, 0, 1};
    vecs[26] = '{0, 1, 6, 32'h66,        0, 0, 0, 0, 0,              0, 0, 0,  1, 6, 32'h66,      0, 0, 1};
    vecs[27] = '{0, 0, 0, 0,             0, 0, 0, 0, 0,              0, 0, 0,  1, 11, 32'hB,      0, 0, 1};
    vecs[28] = '{0, 0, 0, 0,             0, 0, 0, 0, 0,              0, 0, 0,  0, 0, 0,           1, 0, 0};

    for (int i = 0; i < NV; i++) run(vecs[i], i);

    // Re-issue to r9 in the cycle its hold drains: set wins over clear
    v = '{0, 0, 0, 0, 1, 9, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 1, 0, 0};          run(v, 100);
    v = '{0, 0, 0, 0, 1, 9, 0, 0, 0, 9, 0, 0, 1, 9, 32'h99, 0, 1, 0};          run(v, 101);
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 1, 1, 0};               run(v, 102);
    v = '{0, 0, 0, 0, 0, 0, 1, 9, 32'h98, 0, 9, 0, 0, 0, 0, 1, 1, 0};          run(v, 103);
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 1, 9, 32'h98, 0, 1, 0};          run(v, 104);
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 1, 0, 0};               run(v, 105);

    // Reset with a pending hold and busy r3: no write, everything cleared
    v = '{0, 0, 0, 0, 1, 3, 1, 3, 32'h3, 0, 0, 0, 0, 0, 0, 1, 0, 0};           run(v, 200);
    v = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0};               run(v, 201);
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 1, 0, 0};               run(v, 202);
    for (int r = 1; r < 32; r++) begin
      v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, r, r, r, 0, 0, 0, 1, 0, 0};
      run(v, 300 + r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
